// File: rtl/stream_chroma_conv.sv
// Streaming RGB->YCbCr (BT.601, 8-bit) converter with passthrough mode.
// Three pipeline stages (products, rounded sums, offset/clamp) with valid/ready backpressure.
module stream_chroma_conv #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  s_t_valid,
  output logic                  s_t_ready,
  input  logic [DATA_WIDTH-1:0] s_t_data,
  input  logic                  s_t_last,
  output logic                  m_t_valid,
  input  logic                  m_t_ready,
  output logic [DATA_WIDTH-1:0] m_t_data,
  output logic                  m_t_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);
  localparam int LANES = DATA_WIDTH / 32;

  // Row-major: Y (R,G,B), Cb (R,G,B), Cr (R,G,B)
  localparam logic signed [17:0] COEF [9] = '{
    18'sd77,  18'sd150,  18'sd29,
    -18'sd43, -18'sd85,  18'sd128,
    18'sd128, -18'sd107, -18'sd21
  };

  function automatic logic signed [9:0] rnd_shift(input logic signed [17:0] s);
    rnd_shift = 10'((s + 18'sd128) >>> 8);
  endfunction

  function automatic logic [7:0] sat_u8(input logic signed [10:0] v);
    if (v < 11'sd0)
      sat_u8 = 8'd0;
    else if (v > 11'sd255)
      sat_u8 = 8'd255;
    else
      sat_u8 = v[7:0];
  endfunction

  logic                  vld_p0, vld_p1, vld_p2;
  logic                  adv_p0, adv_p1, adv_p2;
  logic                  last_p0, last_p1, last_p2;
  logic                  mode_p0, mode_p1;
  logic [DATA_WIDTH-1:0] raw_p0, raw_p1, data_p2;
  logic signed [17:0]    prod_p0 [LANES][9];
  logic signed [9:0]     sum_p1 [LANES][3];
  logic [DATA_WIDTH-1:0] conv;
  logic                  in_pkt, mode_lat, eff_mode, accept;

  assign adv_p2    = !vld_p2 || m_t_ready;
  assign adv_p1    = !vld_p1 || adv_p2;
  assign adv_p0    = !vld_p0 || adv_p1;
  assign s_t_ready = adv_p0;
  assign accept    = s_t_valid && adv_p0;
  assign eff_mode  = in_pkt ? mode_lat : mode;

  assign m_t_valid = vld_p2;
  assign m_t_data  = data_p2;
  assign m_t_last  = last_p2;
  assign busy      = vld_p0 || vld_p1 || vld_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt   <= 1'b0;
      mode_lat <= 1'b0;
    end else if (accept) begin
      if (!in_pkt)
        mode_lat <= mode;
      in_pkt <= !s_t_last;
    end
  end

  // Stage p0: per-lane coefficient products
  always_ff @(posedge clk) begin
    if (rst)
      vld_p0 <= 1'b0;
    else if (adv_p0)
      vld_p0 <= s_t_valid;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      raw_p0  <= s_t_data;
      last_p0 <= s_t_last;
      mode_p0 <= eff_mode;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < 9; k++)
          prod_p0[l][k] <= COEF[k] * $signed({10'd0, s_t_data[32*l + 8*(2 - k%3) +: 8]});
    end
  end

  // Stage p1: rounded, shifted channel sums
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (adv_p1)
      vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (adv_p1 && vld_p0) begin
      raw_p1  <= raw_p0;
      last_p1 <= last_p0;
      mode_p1 <= mode_p0;
      for (int l = 0; l < LANES; l++)
        for (int c = 0; c < 3; c++)
          sum_p1[l][c] <= rnd_shift(prod_p0[l][3*c] + prod_p0[l][3*c+1] + prod_p0[l][3*c+2]);
    end
  end

  always_comb begin
    conv = '0;
    for (int l = 0; l < LANES; l++) begin
      conv[32*l + 24 +: 8] = raw_p1[32*l + 24 +: 8];
      conv[32*l + 16 +: 8] = sat_u8($signed({sum_p1[l][0][9], sum_p1[l][0]}));
      conv[32*l + 8  +: 8] = sat_u8($signed({sum_p1[l][1][9], sum_p1[l][1]}) + 11'sd128);
      conv[32*l      +: 8] = sat_u8($signed({sum_p1[l][2][9], sum_p1[l][2]}) + 11'sd128);
    end
  end

  // Stage p2: offset/clamp result or passthrough, registered onto the output port
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      last_p2 <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= mode_p1 ? conv : raw_p1;
        last_p2 <= last_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      pkt_cnt <= '0;
    else if (vld_p2 && m_t_ready && last_p2)
      pkt_cnt <= pkt_cnt + 1'b1;
  end
endmodule

// File: tb/tb_stream_chroma_conv.sv
// Bench for stream_chroma_conv: vector table, directed corner sequences and
// randomized traffic checked by a queue-based scoreboard with a pixel model.
module tb_stream_chroma_conv;
  localparam int DW = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          s_t_valid;
  logic          s_t_ready;
  logic [DW-1:0] s_t_data;
  logic          s_t_last;
  logic          m_t_valid;
  logic          m_t_ready;
  logic [DW-1:0] m_t_data;
  logic          m_t_last;
  logic          busy;
  logic [CW-1:0] pkt_cnt;

  stream_chroma_conv #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .s_t_valid(s_t_valid), .s_t_ready(s_t_ready), .s_t_data(s_t_data), .s_t_last(s_t_last),
    .m_t_valid(m_t_valid), .m_t_ready(m_t_ready), .m_t_data(m_t_data), .m_t_last(m_t_last),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic logic [31:0] ref_px(input logic [31:0] p);
    int r, g, b, y, cb, cr;
    r  = int'(p[23:16]);
    g  = int'(p[15:8]);
    b  = int'(p[7:0]);
    y  = clamp8((77*r + 150*g + 29*b + 128) >>> 8);
    cb = clamp8(((-43*r - 85*g + 128*b + 128) >>> 8) + 128);
    cr = clamp8(((128*r - 107*g - 21*b + 128) >>> 8) + 128);
    return {p[31:24], 8'(y), 8'(cb), 8'(cr)};
  endfunction

  function automatic logic [63:0] ref_beat(input logic [63:0] d, input logic md);
    if (!md) return d;
    return {ref_px(d[63:32]), ref_px(d[31:0])};
  endfunction

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t       q[$];
  logic        m_in_pkt = 1'b0;
  logic        m_mode = 1'b0;
  int          exp_pkt = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  // Scoreboard: handshakes observed at negedge occur at the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_in_pkt   = 1'b0;
      m_mode     = 1'b0;
      exp_pkt    = 0;
      prev_stall = 1'b0;
    end else begin
      check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt[CW-1:0]));
      check("busy", 64'(busy), 64'(q.size() != 0));
      check("s_t_ready", 64'(s_t_ready), 64'(!(q.size() == 3 && !m_t_ready)));
      if (prev_stall) begin
        check("hold_data", m_t_data, prev_data);
        check("hold_last", 64'(m_t_last), 64'(prev_last));
      end
      if (m_t_valid && m_t_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          beat_t e;
          e = q.pop_front();
          check("out_data", m_t_data, e.d);
          check("out_last", 64'(m_t_last), 64'(e.l));
          if (m_t_last) exp_pkt++;
        end
      end
      if (s_t_valid && s_t_ready) begin
        beat_t e;
        logic  em;
        em = m_in_pkt ? m_mode : mode;
        if (!m_in_pkt) m_mode = mode;
        m_in_pkt = !s_t_last;
        e.d = ref_beat(s_t_data, em);
        e.l = s_t_last;
        q.push_back(e);
      end
      prev_stall = m_t_valid && !m_t_ready;
      prev_data  = m_t_data;
      prev_last  = m_t_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one beat and hold it until accepted; returns at accept edge + #1.
  task automatic send_beat(input logic [63:0] d, input logic l, input logic md);
    int n;
    s_t_valid = 1'b1;
    s_t_data  = d;
    s_t_last  = l;
    mode      = md;
    n = 0;
    @(negedge clk);
    while (!s_t_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 64'(1), 64'(0));
    @(posedge clk);
    #1;
    s_t_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!m_t_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        md;
    logic [63:0] din;
    logic [63:0] dout;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int lat;
    logic acc;
    vecs[0] = '{md: 1'b1, din: 64'h00FFFFFF_00000000, dout: 64'h00FF8080_00008080};
    vecs[1] = '{md: 1'b1, din: 64'h12FF0000_340000FF, dout: 64'h124D55FF_341DFF6B};
    vecs[2] = '{md: 1'b0, din: 64'hDEADBEEF_01234567, dout: 64'hDEADBEEF_01234567};
    vecs[3] = '{md: 1'b1, din: 64'h5600FF00_00808080, dout: 64'h56952B15_00808080};

    rst = 1'b1; mode = 1'b0; s_t_valid = 1'b0; s_t_data = '0; s_t_last = 1'b0; m_t_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_t_valid", 64'(m_t_valid), 64'(0));
    check("rst_m_t_data", m_t_data, 64'(0));
    check("rst_m_t_last", 64'(m_t_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    rst = 1'b0;

    // Single-beat packets from the vector table
    for (int i = 0; i < 4; i++) begin
      send_beat(vecs[i].din, 1'b1, vecs[i].md);
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(3));
      check($sformatf("vec%0d_data", i), m_t_data, vecs[i].dout);
      check($sformatf("vec%0d_last", i), 64'(m_t_last), 64'(1));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(i + 1));
    end

    // 8-beat passthrough packet, back to back
    for (int i = 0; i < 8; i++) begin
      s_t_valid = 1'b1;
      s_t_data  = 64'h1000_0000_0000_0000 + 64'(i);
      s_t_last  = (i == 7);
      mode      = 1'b0;
      check("burst_s_t_ready", 64'(s_t_ready), 64'(1));
      @(posedge clk);
      #1;
    end
    s_t_valid = 1'b0;
    drain();
    check("burst_pkt_cnt", 64'(pkt_cnt), 64'(5));

    // Backpressure: m_t_ready toggles every cycle while 6 beats stream in
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_beat({$urandom, $urandom}, (i == 5), 1'b1);
      end
      begin
        repeat (30) begin
          @(posedge clk);
          #1;
          m_t_ready = !m_t_ready;
        end
      end
    join
    m_t_ready = 1'b1;
    drain();

    // Mode changes mid-packet are ignored; next packet uses its own mode
    send_beat(64'h12FF0000_340000FF, 1'b0, 1'b1);
    send_beat(64'h5600FF00_00808080, 1'b0, 1'b0);
    send_beat(64'h00FFFFFF_00000000, 1'b1, 1'b0);
    send_beat(64'h12FF0000_340000FF, 1'b1, 1'b0);
    drain();

    // Reset with two beats in flight
    send_beat(64'hAAAA5555_12345678, 1'b0, 1'b0);
    send_beat(64'h0BADF00D_CAFEBABE, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_m_t_valid", 64'(m_t_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    check("midrst_m_t_data", m_t_data, 64'(0));
    rst = 1'b0;
    send_beat(64'h12FF0000_340000FF, 1'b1, 1'b1);
    wait_out(lat);
    check("postrst_latency", 64'(lat), 64'(3));
    check("postrst_data", m_t_data, 64'h124D55FF_341DFF6B);
    @(posedge clk);
    #1;
    check("postrst_pkt_cnt", 64'(pkt_cnt), 64'(1));

    // Randomized traffic with random backpressure and mode flips
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = s_t_valid && s_t_ready;
      @(posedge clk);
      #1;
      if (!s_t_valid || acc) begin
        s_t_valid = ($urandom_range(0, 9) < 7);
        s_t_data  = {$urandom, $urandom};
        s_t_last  = ($urandom_range(0, 3) == 0);
        mode      = 1'($urandom_range(0, 1));
      end
      m_t_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    acc = s_t_valid && s_t_ready;
    @(posedge clk);
    #1;
    while (s_t_valid && !acc) begin
      @(negedge clk);
      acc = s_t_valid && s_t_ready;
      @(posedge clk);
      #1;
    end
    s_t_valid = 1'b0;
    m_t_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
